// File: rtl/car_request_generator.sv
// car_request_generator: synchronises and debounces a car detector and drives the
// controller 'car' request until red is shown or a hold timeout expires.
module car_request_generator #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_MAX        = 12,
  parameter int MIN_GAP         = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  input  logic green,
  input  logic yellow,
  input  logic red,
  output logic car,
  output logic served,
  output logic timeout,
  output logic light_err,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, REQ, SERVE, COOLDOWN} state_t;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  state_t state_q, state_d;
  logic sync1_q, sync2_q;
  logic stable_q, stable_d, prev_q;
  logic pending_q, pending_d;
  logic timeout_q, timeout_d;
  logic light_err_q, light_err_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] hold_inc, gap_inc;
  logic event_det, red_ok;
  assign red_ok    = red & ~green & ~yellow;
  assign event_det = stable_q & ~prev_q;
  assign hold_inc  = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_ONE;
  assign gap_inc   = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + CNT_ONE;
  always_comb begin
    db_cnt_d    = (sync2_q == stable_q || db_cnt_q == DB_LAST) ? '0 :
                  (db_cnt_q == CNT_MAX) ? db_cnt_q : db_cnt_q + CNT_ONE;
    stable_d    = (sync2_q != stable_q && db_cnt_q == DB_LAST) ? sync2_q : stable_q;
    light_err_d = (2'(green) + 2'(yellow) + 2'(red)) != 2'd1;
  end
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (event_det) begin
          state_d    = REQ;
          hold_cnt_d = '0;
        end
      end
      REQ: begin
        hold_cnt_d = hold_inc;
        if (red_ok) begin
          state_d = SERVE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = COOLDOWN;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end
      end
      SERVE: begin
        state_d   = COOLDOWN;
        gap_cnt_d = '0;
      end
      COOLDOWN: begin
        gap_cnt_d = gap_inc;
        if (gap_cnt_q == GAP_LAST) begin
          state_d    = (pending_q | event_det) ? REQ : IDLE;
          hold_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // a press that coincides with entering REQ is consumed by that request
    pending_d = (state_d == REQ && state_q != REQ) ? 1'b0 :
                pending_q | (event_det && state_q != IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      prev_q      <= 1'b0;
      pending_q   <= 1'b0;
      timeout_q   <= 1'b0;
      light_err_q <= 1'b0;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sensor_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      pending_q   <= pending_d;
      timeout_q   <= timeout_d;
      light_err_q <= light_err_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end
  assign car       = state_q == REQ;
  assign served    = state_q == SERVE;
  assign busy      = state_q != IDLE;
  assign timeout   = timeout_q;
  assign light_err = light_err_q;
endmodule
